// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and position type for the sync generator.
// Defaults describe 640x480 at 60 Hz with a 25.175 MHz-class pixel clock.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [POS_W-1:0] pos_t;

    // Inclusive window test used for the active-low sync pulses.
    function automatic logic in_window(input pos_t p, input pos_t lo, input pos_t hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with enable, synchronous clear and a wrap strobe that is
// high on the enabled cycle in which the count returns to zero.
module wrap_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_reg;
    logic             at_max;

    assign at_max = (count_reg == WIDTH'(MODULUS - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= at_max ? '0 : count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign wrap  = en && at_max;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: horizontal/vertical position counters with sync, blanking
// and line/frame markers decoded combinationally from the current position.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ce,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_PERIOD = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_PERIOD = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam pos_t H_SYNC_START = pos_t'(H_DISPLAY + H_FRONT);
    localparam pos_t H_SYNC_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam pos_t V_SYNC_START = pos_t'(V_DISPLAY + V_FRONT);
    localparam pos_t V_SYNC_END   = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam pos_t H_VISIBLE    = pos_t'(H_DISPLAY);
    localparam pos_t V_VISIBLE    = pos_t'(V_DISPLAY);

    logic h_wrap;
    logic v_wrap_unused;

    wrap_counter #(
        .MODULUS (H_PERIOD),
        .WIDTH   (POS_W)
    ) u_h_counter (
        .clk   (clk_in),
        .srst  (rst),
        .en    (ce),
        .count (hpos),
        .wrap  (h_wrap)
    );

    // The line counter only advances on the pixel edge that ends a line.
    wrap_counter #(
        .MODULUS (V_PERIOD),
        .WIDTH   (POS_W)
    ) u_v_counter (
        .clk   (clk_in),
        .srst  (rst),
        .en    (h_wrap),
        .count (vpos),
        .wrap  (v_wrap_unused)
    );

    assign hsync       = ~in_window(hpos, H_SYNC_START, H_SYNC_END);
    assign vsync       = ~in_window(vpos, V_SYNC_START, V_SYNC_END);
    assign display_on  = (hpos < H_VISIBLE) && (vpos < V_VISIBLE);
    assign line_start  = (hpos == '0);
    assign frame_start = (hpos == '0) && (vpos == '0);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync using a reduced raster (30x21) so whole frames stay short;
// a linear pixel-index model is compared against the DUT on every cycle.
module tb_vga_sync;

    localparam int HD = 16, HF = 4, HS = 6, HB = 4;
    localparam int VD = 12, VF = 3, VS = 2, VB = 4;
    localparam int HT = HD + HF + HS + HB;   // 30
    localparam int VT = VD + VF + VS + VB;   // 21

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [9:0] hpos, vpos;
    logic       hsync, vsync, display_on, line_start, frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_sync #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk_in      (clk),
        .rst         (rst),
        .ce          (ce),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // Model: a single pixel index within the frame; position is derived by division.
    int model_pos   = 0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_pos   = 0;
            model_valid = 1'b1;
        end else if (ce) begin
            model_pos = (model_pos + 1) % (HT * VT);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            int eh, ev;
            logic ehs, evs, edisp, els, efs;
            eh    = model_pos % HT;
            ev    = model_pos / HT;
            ehs   = !(eh >= HD + HF && eh < HD + HF + HS);
            evs   = !(ev >= VD + VF && ev < VD + VF + VS);
            edisp = (eh < HD) && (ev < VD);
            els   = (eh == 0);
            efs   = (eh == 0) && (ev == 0);
            checks++;
            if (hpos !== 10'(eh) || vpos !== 10'(ev) || hsync !== ehs || vsync !== evs ||
                display_on !== edisp || line_start !== els || frame_start !== efs) begin
                errors++;
                $display("FAIL model t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                         $time, hpos, vpos, hsync, vsync, display_on, line_start, frame_start,
                         eh, ev, ehs, evs, edisp, els, efs);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, actual, expected);
        end else begin
            $display("ok   %s = %0d", name, actual);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hs_low, first_hs, first_blank, vs_low, fs_seen;

        // Reset held for three edges with ce asserted
        rst = 1'b1; ce = 1'b1;
        step(3);
        check("rst_hpos", hpos, 0);
        check("rst_vpos", vpos, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_display_on", display_on, 1);
        check("rst_line_start", line_start, 1);
        check("rst_frame_start", frame_start, 1);

        // End of first line and wrap into line 1
        rst = 1'b0;
        step(HT - 1);
        check("eol_hpos", hpos, 29);
        check("eol_vpos", vpos, 0);
        step(1);
        check("wrap_hpos", hpos, 0);
        check("wrap_vpos", vpos, 1);
        check("wrap_line_start", line_start, 1);
        check("wrap_frame_start", frame_start, 0);

        // One full line of line 1
        hs_low = 0; first_hs = -1; first_blank = -1;
        for (int i = 0; i < HT; i++) begin
            if (hsync === 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = hpos;
            end
            if (display_on === 1'b0 && first_blank < 0) first_blank = hpos;
            step(1);
        end
        check("line_hsync_low_cycles", hs_low, 6);
        check("line_hsync_first_h", first_hs, 20);
        check("line_blank_first_h", first_blank, 16);

        // One full frame worth of cycles
        vs_low = 0; fs_seen = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) fs_seen++;
            step(1);
        end
        check("frame_vsync_low_cycles", vs_low, 60);
        check("frame_start_count", fs_seen, 1);

        // Freeze at the last pixel of the frame, then wrap both counters
        step((VT - 1) * HT + (HT - 1) - 2 * HT);
        check("last_hpos", hpos, 29);
        check("last_vpos", vpos, 20);
        ce = 1'b0;
        step(10);
        check("frozen_hpos", hpos, 29);
        check("frozen_vpos", vpos, 20);
        ce = 1'b1;
        step(1);
        check("frame_wrap_hpos", hpos, 0);
        check("frame_wrap_vpos", vpos, 0);
        check("frame_wrap_fs", frame_start, 1);

        // Mid-frame reset pulse at (10,5)
        step(5 * HT + 10);
        check("pre_rst_hpos", hpos, 10);
        check("pre_rst_vpos", vpos, 5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_hpos", hpos, 0);
        check("mid_rst_vpos", vpos, 0);
        step(1);
        check("resume_hpos", hpos, 1);
        check("resume_vpos", vpos, 0);

        // Reset held at an arbitrary position with ce random
        step($urandom_range(50, 400));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ce = 1'($urandom);
            step(1);
        end
        rst = 1'b0; ce = 1'b1;
        check("arb_rst_hpos", hpos, 0);
        check("arb_rst_vpos", vpos, 0);
        check("arb_rst_frame_start", frame_start, 1);

        // Random ce and occasional reset; the model compare checks every cycle
        for (int i = 0; i < 3000; i++) begin
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
